// File: rtl/vga_timing_pkg.sv
// Shared types, default 640x480@60 timing constants and a frame-total helper.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        MODE_1X = 2'b00,
        MODE_2X = 2'b01,
        MODE_4X = 2'b10
    } mode_e;

    localparam int DEF_H_ACT  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_V_ACT  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;

    function automatic int total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_scaled_timing_gen_if.sv
// Video-side bundle between the timing generator, framebuffer read port and DAC.
// Latency: n/a (wiring only).
// Backpressure: none; the video stream is free-running.
interface vga_scaled_timing_gen_if #(
    parameter int CNT_W  = 10,
    parameter int ADDR_W = 19
);
    logic [1:0]        mode;
    logic [ADDR_W-1:0] fb_addr;
    logic [CNT_W-1:0]  hcount;
    logic [CNT_W-1:0]  vcount;
    logic              Hsync;
    logic              Vsync;
    logic              Nblank;
    logic              activeArea;
    logic              line_start;
    logic              frame_start;
    logic              Nsync;
    logic              clkout;

    modport master (
        input  mode,
        output fb_addr, hcount, vcount, Hsync, Vsync, Nblank, activeArea,
               line_start, frame_start, Nsync, clkout
    );

    modport slave (
        output mode,
        input  fb_addr, hcount, vcount, Hsync, Vsync, Nblank, activeArea,
               line_start, frame_start, Nsync, clkout
    );
endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register that aligns video strobes with framebuffer data.
// Latency: DEPTH cycles.
// Backpressure: none; shifts every cycle, asynchronous clear flushes all stages.
module vga_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] pipe [DEPTH];

    // shift every cycle; reset empties the whole line so no stale strobes leak out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[DEPTH-1];
endmodule

// File: rtl/vga_scaled_timing_gen.sv
// VGA timing generator with programmable porches/polarity and 1x/2x/4x framebuffer replication.
// Latency: fb_addr 1 cycle after the stage-0 pixel; all other video outputs 1+RD_LAT cycles.
// Backpressure: none; free-running at the pixel clock.
module vga_scaled_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACT  = DEF_H_ACT,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_ACT  = DEF_V_ACT,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 10,
    parameter int ADDR_W = 19
) (
    input  logic CLK25,
    input  logic Nrst,
    vga_scaled_timing_gen_if.master vid
);
    localparam int H_TOTAL = total(H_ACT, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total(V_ACT, V_FP, V_SYNC, V_BP);

    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam cnt_t  H_LAST     = cnt_t'(H_TOTAL - 1);
    localparam cnt_t  V_LAST     = cnt_t'(V_TOTAL - 1);
    localparam cnt_t  H_VIS      = cnt_t'(H_ACT);
    localparam cnt_t  V_VIS      = cnt_t'(V_ACT);
    localparam cnt_t  H_VIS_LAST = cnt_t'(H_ACT - 1);
    localparam cnt_t  HS_BEG     = cnt_t'(H_ACT + H_FP);
    localparam cnt_t  HS_END     = cnt_t'(H_ACT + H_FP + H_SYNC);
    localparam cnt_t  VS_BEG     = cnt_t'(V_ACT + V_FP);
    localparam cnt_t  VS_END     = cnt_t'(V_ACT + V_FP + V_SYNC);
    localparam cnt_t  CNT_ONE    = cnt_t'(1);
    localparam addr_t ADDR_ONE   = addr_t'(1);

    typedef struct packed {
        logic hs;   // sync active (polarity applied at the output)
        logic vs;
        logic vis;
        logic ls;
        logic fs;
        cnt_t h;
        cnt_t v;
    } stage_t;

    cnt_t   h, v;
    logic   h_wrap, v_wrap, frame_wrap, visible;
    mode_e  mode_q;
    cnt_t   pix_mask;
    addr_t  src_w;
    addr_t  fb_addr_q, addr_nxt, line_base, next_base;
    stage_t stg0, stg_out;

    assign h_wrap     = (h == H_LAST);
    assign v_wrap     = (v == V_LAST);
    assign frame_wrap = h_wrap & v_wrap;
    assign visible    = (h < H_VIS) && (v < V_VIS);

    // stage-0 raster counters
    always_ff @(posedge CLK25 or negedge Nrst) begin
        if (!Nrst) begin
            h <= '0;
            v <= '0;
        end else if (h_wrap) begin
            h <= '0;
            v <= v_wrap ? '0 : v + CNT_ONE;
        end else begin
            h <= h + CNT_ONE;
        end
    end

    // replication mode only changes between frames so a frame is never mixed
    always_ff @(posedge CLK25 or negedge Nrst) begin
        if (!Nrst) begin
            mode_q <= MODE_1X;
        end else if (frame_wrap) begin
            mode_q <= (vid.mode == 2'b11) ? MODE_1X : mode_e'(vid.mode);
        end
    end

    // per-mode pixel mask (h[s-1:0]) and source line width (H_ACT >> s)
    always_comb begin
        pix_mask = '0;
        src_w    = addr_t'(H_ACT);
        case (mode_q)
            MODE_2X: begin
                pix_mask = cnt_t'(1);
                src_w    = addr_t'(H_ACT / 2);
            end
            MODE_4X: begin
                pix_mask = cnt_t'(3);
                src_w    = addr_t'(H_ACT / 4);
            end
            default: begin
                pix_mask = '0;
                src_w    = addr_t'(H_ACT);
            end
        endcase
    end

    assign next_base = line_base + src_w;

    // address walk: addr_nxt is the source index the next visible pixel reads
    always_ff @(posedge CLK25 or negedge Nrst) begin
        if (!Nrst) begin
            fb_addr_q <= '0;
            addr_nxt  <= '0;
            line_base <= '0;
        end else if (frame_wrap) begin
            fb_addr_q <= '0;
            addr_nxt  <= '0;
            line_base <= '0;
        end else if (visible) begin
            fb_addr_q <= addr_nxt;
            if (h == H_VIS_LAST) begin
                // repeat the source line until the last replicated output line
                if ((v & pix_mask) != pix_mask) begin
                    addr_nxt <= line_base;
                end else begin
                    line_base <= next_base;
                    addr_nxt  <= next_base;
                end
            end else if ((h & pix_mask) == pix_mask) begin
                addr_nxt <= addr_nxt + ADDR_ONE;
            end
        end
    end

    // stage-0 strobes feeding the alignment delay line
    always_comb begin
        stg0     = '0;
        stg0.hs  = (h >= HS_BEG) && (h < HS_END);
        stg0.vs  = (v >= VS_BEG) && (v < VS_END);
        stg0.vis = visible;
        stg0.ls  = (h == '0) && (v < V_VIS);
        stg0.fs  = (h == '0) && (v == '0);
        stg0.h   = h;
        stg0.v   = v;
    end

    vga_delay_line #(
        .WIDTH ($bits(stage_t)),
        .DEPTH (1 + RD_LAT)
    ) u_dly (
        .clk   (CLK25),
        .rst_n (Nrst),
        .din   (stg0),
        .dout  (stg_out)
    );

    assign vid.fb_addr     = fb_addr_q;
    assign vid.hcount      = stg_out.h;
    assign vid.vcount      = stg_out.v;
    assign vid.Hsync       = stg_out.hs ? HS_POL : ~HS_POL;
    assign vid.Vsync       = stg_out.vs ? VS_POL : ~VS_POL;
    assign vid.Nblank      = stg_out.vis;
    assign vid.activeArea  = stg_out.vis;
    assign vid.line_start  = stg_out.ls;
    assign vid.frame_start = stg_out.fs;
    assign vid.Nsync       = 1'b1;
    assign vid.clkout      = CLK25;
endmodule

// File: tb/tb_vga_scaled_timing_gen.sv
// Bench for the scaled VGA timing generator using a reduced 16x8 raster.
// Instance A: RD_LAT=1, active-low syncs, full scoreboard; instance B: RD_LAT=3, active-high syncs.
// Expected outputs are queued per stage-0 pixel and popped when they should emerge.
module tb_vga_scaled_timing_gen;
    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;   // 24
    localparam int VT = VA + VF + VS + VB;   // 13
    localparam int CW = 5;
    localparam int AW = 7;
    localparam int LAT_A = 2;                // 1 + RD_LAT
    localparam int LAT_B = 4;

    logic CLK25 = 1'b0;
    logic Nrst_a = 1'b0;
    logic Nrst_b = 1'b0;
    always #5 CLK25 = ~CLK25;

    vga_scaled_timing_gen_if #(.CNT_W(CW), .ADDR_W(AW)) vid_a ();
    vga_scaled_timing_gen_if #(.CNT_W(CW), .ADDR_W(AW)) vid_b ();

    vga_scaled_timing_gen #(
        .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .RD_LAT(1), .CNT_W(CW), .ADDR_W(AW)
    ) u_a (
        .CLK25 (CLK25),
        .Nrst  (Nrst_a),
        .vid   (vid_a)
    );

    vga_scaled_timing_gen #(
        .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .RD_LAT(3), .CNT_W(CW), .ADDR_W(AW)
    ) u_b (
        .CLK25 (CLK25),
        .Nrst  (Nrst_b),
        .vid   (vid_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // {Hsync, Vsync, Nblank, activeArea, line_start, frame_start, Nsync, clkout, hcount, vcount}
    typedef logic [17:0] vrec_t;
    localparam vrec_t RST_REC = {8'b1100_0010, 5'd0, 5'd0};

    vrec_t vq[$];
    int    aq[$];

    // scoreboard for instance A: reference raster + direct address formula
    initial begin
        int mh, mv, mode_m, last_addr, sh, a;
        bit vis, hsa, vsa, ls, fs;
        vrec_t obs;
        mh = 0; mv = 0; mode_m = 0; last_addr = 0;
        forever begin
            @(negedge CLK25);
            if (!Nrst_a) begin
                vq.delete();
                aq.delete();
                for (int i = 0; i < LAT_A; i++) vq.push_back(RST_REC);
                aq.push_back(0);
                mh = 0; mv = 0; mode_m = 0; last_addr = 0;
            end else begin
                sh  = (mode_m == 1) ? 1 : (mode_m == 2) ? 2 : 0;
                vis = (mh < HA) && (mv < VA);
                hsa = (mh >= HA + HF) && (mh < HA + HF + HS);
                vsa = (mv >= VA + VF) && (mv < VA + VF + VS);
                ls  = (mh == 0) && (mv < VA);
                fs  = (mh == 0) && (mv == 0);
                if (mh == HT - 1 && mv == VT - 1) a = 0;
                else if (vis) a = (mv >> sh) * (HA >> sh) + (mh >> sh);
                else a = last_addr;
                last_addr = a;
                vq.push_back({~hsa, ~vsa, vis, vis, ls, fs, 1'b1, 1'b0, 5'(mh), 5'(mv)});
                aq.push_back(a);
                obs = {vid_a.Hsync, vid_a.Vsync, vid_a.Nblank, vid_a.activeArea,
                       vid_a.line_start, vid_a.frame_start, vid_a.Nsync, vid_a.clkout,
                       vid_a.hcount, vid_a.vcount};
                chk("a_video", 64'(obs), 64'(vq.pop_front()));
                chk("a_fb_addr", 64'(vid_a.fb_addr), 64'(aq.pop_front()));
                if (mh == HT - 1) begin
                    mh = 0;
                    if (mv == VT - 1) begin
                        mv = 0;
                        mode_m = (vid_a.mode == 2'b11) ? 0 : int'(vid_a.mode);
                    end else begin
                        mv++;
                    end
                end else begin
                    mh++;
                end
            end
        end
    end

    // one full frame of A from frame_start to frame_start: period, peak address, sync duty
    task automatic measure_frame(input string tag, input int exp_max);
        bit seen, got;
        int n, mx, hs_lo, vs_lo;
        seen = 0; got = 0; n = 0; mx = 0; hs_lo = 0; vs_lo = 0;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            @(negedge CLK25);
            if (vid_a.frame_start) begin
                seen = 1;
                break;
            end
        end
        chk({tag, "_fs_seen"}, 64'(seen), 64'(1));
        for (int i = 0; i < 2 * HT * VT; i++) begin
            if (int'(vid_a.fb_addr) > mx) mx = int'(vid_a.fb_addr);
            if (!vid_a.Hsync) hs_lo++;
            if (!vid_a.Vsync) vs_lo++;
            n++;
            @(negedge CLK25);
            if (vid_a.frame_start) begin
                got = 1;
                break;
            end
        end
        chk({tag, "_fs_next"}, 64'(got), 64'(1));
        chk({tag, "_fs_period"}, 64'(n), 64'(HT * VT));
        chk({tag, "_max_addr"}, 64'(mx), 64'(exp_max));
        chk({tag, "_hs_low"}, 64'(hs_lo), 64'(HS * VT));
        chk({tag, "_vs_low"}, 64'(vs_lo), 64'(VS * HT));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int hi_h, hi_v;
        vid_a.mode = 2'b00;
        vid_b.mode = 2'b00;
        repeat (3) @(negedge CLK25);

        // held in reset
        chk("a_rst_hsync", 64'(vid_a.Hsync), 64'(1));
        chk("a_rst_vsync", 64'(vid_a.Vsync), 64'(1));
        chk("a_rst_nblank", 64'(vid_a.Nblank), 64'(0));
        chk("a_rst_active", 64'(vid_a.activeArea), 64'(0));
        chk("a_rst_ls", 64'(vid_a.line_start), 64'(0));
        chk("a_rst_fs", 64'(vid_a.frame_start), 64'(0));
        chk("a_rst_addr", 64'(vid_a.fb_addr), 64'(0));
        chk("a_rst_nsync", 64'(vid_a.Nsync), 64'(1));
        chk("b_rst_hsync", 64'(vid_b.Hsync), 64'(0));
        chk("b_rst_vsync", 64'(vid_b.Vsync), 64'(0));

        @(posedge CLK25);
        #2;
        Nrst_a = 1'b1;
        Nrst_b = 1'b1;

        measure_frame("x1", HA * VA - 1);

        // mid-frame change: current frame must stay 1x (scoreboard), next frame 2x
        found = 0;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            @(negedge CLK25);
            if (vid_a.vcount == 5'd4) begin
                found = 1;
                break;
            end
        end
        chk("a_reach_v4", 64'(found), 64'(1));
        @(posedge CLK25);
        #3 vid_a.mode = 2'b01;
        measure_frame("x2", (VA / 2) * (HA / 2) - 1);

        @(posedge CLK25);
        #3 vid_a.mode = 2'b10;
        measure_frame("x4", (VA / 4) * (HA / 4) - 1);

        @(posedge CLK25);
        #3 vid_a.mode = 2'b11;
        measure_frame("x11", HA * VA - 1);

        // instance B: active-high sync duty over any one-frame window
        hi_h = 0; hi_v = 0;
        for (int i = 0; i < HT * VT; i++) begin
            @(negedge CLK25);
            if (vid_b.Hsync) hi_h++;
            if (vid_b.Vsync) hi_v++;
        end
        chk("b_hs_high", 64'(hi_h), 64'(HS * VT));
        chk("b_vs_high", 64'(hi_v), 64'(VS * HT));

        // instance B: reset pulse while the stage-0 raster is at (10,5)
        found = 0;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            @(negedge CLK25);
            if (vid_b.hcount == 5'd6 && vid_b.vcount == 5'd5) begin
                found = 1;
                break;
            end
        end
        chk("b_reach_pos", 64'(found), 64'(1));
        chk("b_pre_nblank", 64'(vid_b.Nblank), 64'(1));
        chk("b_pre_addr", 64'(vid_b.fb_addr), 64'(5 * HA + 9));
        #1 Nrst_b = 1'b0;
        #1;
        chk("b_mid_nblank", 64'(vid_b.Nblank), 64'(0));
        chk("b_mid_hsync", 64'(vid_b.Hsync), 64'(0));
        chk("b_mid_vsync", 64'(vid_b.Vsync), 64'(0));
        chk("b_mid_addr", 64'(vid_b.fb_addr), 64'(0));
        chk("b_mid_hcount", 64'(vid_b.hcount), 64'(0));
        chk("b_mid_vcount", 64'(vid_b.vcount), 64'(0));
        @(posedge CLK25);
        @(posedge CLK25);
        #2 Nrst_b = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK25);
            chk($sformatf("b_rel_fs_%0d", k), 64'(vid_b.frame_start), 64'(k == LAT_B));
            chk($sformatf("b_rel_nblank_%0d", k), 64'(vid_b.Nblank), 64'(k >= LAT_B));
            chk($sformatf("b_rel_hcount_%0d", k), 64'(vid_b.hcount), 64'((k >= LAT_B) ? k - LAT_B : 0));
            chk($sformatf("b_rel_addr_%0d", k), 64'(vid_b.fb_addr), 64'((k >= 1) ? k - 1 : 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
